// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO push-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE = arbitrating, LOCKED = a requester owns the port)
//   grant_w()   : width of grant_id / round-robin pointer for N requesters (never below 1)
package fifo_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_m.sv
// Two-entry skid buffer between the granted requester and the FIFO write port.
//   clk, rst   : clock, synchronous active-high reset (contents zeroed)
//   in_valid   : beat offered by the granted requester
//   in_ready   : room available (fewer than two beats held)
//   in_data    : offered beat
//   out_valid  : at least one beat held
//   out_pop    : consumer takes the head beat this cycle
//   out_data   : head beat (oldest)
// Handshake: a beat moves when valid and ready are both high on a rising clk
// edge; ready never depends combinationally on valid.
module fifo_skid_m #(
    parameter type DATA_ITEM_TYPE = logic
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  DATA_ITEM_TYPE in_data,
    output logic          out_valid,
    input  logic          out_pop,
    output DATA_ITEM_TYPE out_data
);

    logic [1:0]    cnt_q;
    DATA_ITEM_TYPE mem0_q;   // head
    DATA_ITEM_TYPE mem1_q;   // second entry, only meaningful when cnt_q == 2
    logic          wr;
    logic          rd;

    assign in_ready  = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem0_q;
    assign wr        = in_valid & in_ready;
    assign rd        = out_pop & out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            mem0_q <= '0;
            mem1_q <= '0;
        end else begin
            case ({wr, rd})
                2'b10: begin
                    if (cnt_q == 2'd0) mem0_q <= in_data;
                    else               mem1_q <= in_data;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    mem0_q <= mem1_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Write and pop together: count unchanged, new beat goes behind
                    // whatever remains after the pop.
                    if (cnt_q == 2'd1) begin
                        mem0_q <= in_data;
                    end else begin
                        mem0_q <= mem1_q;
                        mem1_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_push_arb_m.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among N requesters.
//   clk, rst     : FIFO write clock, synchronous active-high reset
//   req_valid    : per-requester beat valid
//   req_data     : per-requester beat
//   req_last     : per-requester last-beat-of-packet marker
//   req_ready    : per-requester beat accept (at most one high)
//   tail, push   : FIFO write data / write enable
//   full         : FIFO full
//   wr_rst_busy  : FIFO write side still in reset
//   grant_id     : current or most recent granted requester
//   busy         : a grant is held or the skid buffer holds beats
//   burst_cut    : one-cycle pulse after a grant is released by the burst cap
// Handshake: a requester beat is taken when req_valid[i] and req_ready[i] are
// both high on a rising clk edge; a requester must hold valid and data until then.
module fifo_push_arb_m
    import fifo_arb_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  N              = 4,
    parameter int  MAX_BURST      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  DATA_ITEM_TYPE          req_data [N],
    input  logic [N-1:0]           req_last,
    output logic [N-1:0]           req_ready,
    output DATA_ITEM_TYPE          tail,
    output logic                   push,
    input  logic                   full,
    input  logic                   wr_rst_busy,
    output logic [grant_w(N)-1:0]  grant_id,
    output logic                   busy,
    output logic                   burst_cut
);

    localparam int GW = grant_w(N);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e    state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic          burst_cut_q, burst_cut_d;

    logic [GW-1:0] winner;
    logic          win_found;
    logic          g_valid;
    logic          g_last;
    DATA_ITEM_TYPE g_data;
    logic          skid_in_valid;
    logic          skid_ready;
    logic          skid_out_valid;
    logic          accept;
    logic          cap_hit;

    // First valid requester at or above rr_ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        win_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!win_found && req_valid[idx]) begin
                winner    = GW'(idx);
                win_found = 1'b1;
            end
        end
    end

    assign g_valid       = req_valid[grant_q];
    assign g_last        = req_last[grant_q];
    assign g_data        = req_data[grant_q];
    assign skid_in_valid = (state_q == LOCKED) & g_valid;
    assign accept        = skid_in_valid & skid_ready;
    // beat_cnt counts beats already taken in this grant, so the beat being
    // accepted when it equals MAX_BURST-1 is the last one allowed.
    assign cap_hit       = (MAX_BURST != 0) && (beat_cnt_q == BW'(MAX_BURST - 1));

    always_comb begin
        req_ready = '0;
        if (state_q == LOCKED && skid_ready) req_ready[grant_q] = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cut_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found && !wr_rst_busy) begin
                    state_d    = LOCKED;
                    grant_d    = winner;
                    rr_ptr_d   = (winner == GW'(N - 1)) ? '0 : winner + 1'b1;
                    beat_cnt_d = '0;
                end
            end
            LOCKED: begin
                if (accept) begin
                    beat_cnt_d  = beat_cnt_q + 1'b1;
                    burst_cut_d = cap_hit;
                    if (g_last || cap_hit) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            beat_cnt_q  <= '0;
            burst_cut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cut_q <= burst_cut_d;
        end
    end

    fifo_skid_m #(.DATA_ITEM_TYPE(DATA_ITEM_TYPE)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_ready),
        .in_data   (g_data),
        .out_valid (skid_out_valid),
        .out_pop   (push),
        .out_data  (tail)
    );

    // push uses only the registered skid occupancy plus the two FIFO inputs.
    assign push      = skid_out_valid & !full & !wr_rst_busy;
    assign busy      = (state_q == LOCKED) | skid_out_valid;
    assign grant_id  = grant_q;
    assign burst_cut = burst_cut_q;

    a_no_push_full: assert property (@(posedge clk) !(push && full));
    a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

    for (genvar i = 0; i < N; i++) begin : g_req_sva
        a_req_stable: assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=> (req_valid[i] && $stable(req_data[i])));
    end

endmodule

// File: tb/tb_fifo_push_arb_m.sv
module tb_fifo_push_arb_m;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int W  = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [W-1:0] req_data [N];
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic [W-1:0] tail;
    logic         push;
    logic         full;
    logic         wr_rst_busy;
    logic [1:0]   grant_id;
    logic         busy;
    logic         burst_cut;

    fifo_push_arb_m #(
        .DATA_ITEM_TYPE (logic [W-1:0]),
        .N              (N),
        .MAX_BURST      (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tail        (tail),
        .push        (push),
        .full        (full),
        .wr_rst_busy (wr_rst_busy),
        .grant_id    (grant_id),
        .busy        (busy),
        .burst_cut   (burst_cut)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_cut  = 0;
    bit mon_en = 1'b0;

    logic [W:0]   rq [N][$];     // per-requester pending beats, bit W = last
    logic [N-1:0] hs;            // DUT handshakes seen before the coming edge
    int           acc_log[$];    // requester index of each accepted beat
    int           acc_cyc[$];    // cycle of each accepted beat
    logic [W-1:0] push_log[$];   // values written to the FIFO

    // Model: beats accepted but not yet written, in order.
    logic [W-1:0] exp_q[$];
    bit           m_locked = 1'b0;
    int           m_owner  = 0;
    int           m_ptr    = 0;
    int           m_gid    = 0;
    int           m_beats  = 0;
    bit           m_cut    = 1'b0;
    logic [N-1:0] e_ready;
    logic         e_push;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- driver ----------------
    function automatic void apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (rq[i].size() > 0);
            req_data[i]  = (rq[i].size() > 0) ? rq[i][0][W-1:0] : '0;
            req_last[i]  = (rq[i].size() > 0) ? rq[i][0][W] : 1'b0;
        end
    endfunction

    task automatic tick();
        logic [W:0] tmp;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                tmp = rq[i].pop_front();
                acc_log.push_back(i);
                acc_cyc.push_back(cyc);
            end
        end
        apply();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        full        = 1'b0;
        wr_rst_busy = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        apply();
        tick();
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic add_beat(input int r, input logic last, input logic [W-1:0] d);
        rq[r].push_back({last, d});
    endtask

    // ---------------- model + compare (outputs stable at negedge) ----------------
    always @(negedge clk) begin
        hs = '0;
        if (mon_en) begin
            e_ready = '0;
            if (m_locked && exp_q.size() < 2) e_ready[m_owner] = 1'b1;
            e_push = (exp_q.size() > 0) && !full && !wr_rst_busy;

            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("push", 32'(push), 32'(e_push));
            check("grant_id", 32'(grant_id), 32'(m_gid));
            check("busy", 32'(busy), 32'(m_locked || exp_q.size() > 0));
            check("burst_cut", 32'(burst_cut), 32'(m_cut));
            if (e_push) check("tail", 32'(tail), 32'(exp_q[0]));
            if (push) push_log.push_back(tail);
            if (burst_cut) n_cut++;

            if (rst) begin
                exp_q.delete();
                m_locked = 1'b0;
                m_owner  = 0;
                m_ptr    = 0;
                m_gid    = 0;
                m_beats  = 0;
                m_cut    = 1'b0;
            end else begin
                hs = req_valid & req_ready;
                if (e_push) exp_q.pop_front();
                m_cut = 1'b0;
                if (m_locked) begin
                    if (req_valid[m_owner] && e_ready[m_owner]) begin
                        exp_q.push_back(req_data[m_owner]);
                        m_beats++;
                        if (MB != 0 && m_beats == MB) m_cut = 1'b1;
                        if (req_last[m_owner] || m_cut) m_locked = 1'b0;
                    end
                end else if (req_valid != '0 && !wr_rst_busy) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && req_valid[(m_ptr + k) % N]) begin
                            m_owner = (m_ptr + k) % N;
                            found   = 1'b1;
                        end
                    end
                    m_gid    = m_owner;
                    m_ptr    = (m_owner + 1) % N;
                    m_beats  = 0;
                    m_locked = 1'b1;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int exp3 [12];
        exp3 = '{1, 1, 1, 1, 2, 0, 1, 1, 1, 1, 1, 1};

        // Test 1: reset values, then requester 2 sends a 3-beat packet.
        do_reset();
        #1;
        check("rst_push", 32'(push), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cut", 32'(burst_cut), 32'd0);
        check("rst_tail", 32'(tail), 32'd0);
        add_beat(2, 1'b0, 8'h21);
        add_beat(2, 1'b0, 8'h22);
        add_beat(2, 1'b1, 8'h23);
        apply();
        tick(); #1;
        check("t1_ready_c1", 32'(req_ready), 32'h4);
        check("t1_push_c1", 32'(push), 32'd0);
        tick(); #1;
        check("t1_push_c2", 32'(push), 32'd1);
        check("t1_tail_c2", 32'(tail), 32'h21);
        tick(); #1;
        check("t1_tail_c3", 32'(tail), 32'h22);
        tick(); #1;
        check("t1_tail_c4", 32'(tail), 32'h23);
        check("t1_ready_c4", 32'(req_ready), 32'd0);
        tick(); #1;
        check("t1_busy_c5", 32'(busy), 32'd0);
        check("t1_push_c5", 32'(push), 32'd0);
        check("t1_grant_c5", 32'(grant_id), 32'd2);
        // rr_ptr is now 3: with 0 and 3 both asking, 3 must win.
        add_beat(0, 1'b1, 8'h30);
        add_beat(3, 1'b1, 8'h33);
        apply();
        tick(); #1;
        check("t1_rrptr", 32'(req_ready), 32'h8);
        ticks(8);

        // Test 2: all four continuously valid with 1-beat packets.
        do_reset();
        acc_log.delete();
        acc_cyc.delete();
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < N; i++) add_beat(i, 1'b1, 8'(8'h40 + i * 16 + p));
        apply();
        ticks(32);
        check("t2_count", 32'(acc_log.size()), 32'd12);
        for (int k = 0; k < 5; k++) begin
            if (k < acc_log.size()) check("t2_order", 32'(acc_log[k]), 32'(k % N));
            if (k + 1 < acc_cyc.size()) check("t2_bubble", 32'(acc_cyc[k + 1] - acc_cyc[k]), 32'd2);
        end

        // Test 3: requester 1 streams 10 beats without last; cap of 4 forces release.
        do_reset();
        acc_log.delete();
        n_cut = 0;
        for (int k = 0; k < 10; k++) add_beat(1, 1'b0, 8'(8'h60 + k));
        apply();
        tick();
        add_beat(0, 1'b1, 8'h70);
        add_beat(2, 1'b1, 8'h72);
        apply();
        ticks(30);
        check("t3_count", 32'(acc_log.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            if (k < acc_log.size()) check("t3_order", 32'(acc_log[k]), 32'(exp3[k]));
        check("t3_cuts", 32'(n_cut), 32'd2);

        // Test 4: full held for 5 cycles mid-packet.
        do_reset();
        push_log.delete();
        add_beat(3, 1'b0, 8'h81);
        add_beat(3, 1'b0, 8'h82);
        add_beat(3, 1'b1, 8'h83);
        apply();
        tick();
        tick();
        full = 1'b1;
        #1;
        check("t4_push_c2", 32'(push), 32'd0);
        tick(); #1;
        check("t4_ready_c3", 32'(req_ready), 32'd0);
        check("t4_busy_c3", 32'(busy), 32'd1);
        ticks(3); #1;
        check("t4_ready_c6", 32'(req_ready), 32'd0);
        check("t4_push_c6", 32'(push), 32'd0);
        tick();
        full = 1'b0;
        ticks(8);
        check("t4_npush", 32'(push_log.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < push_log.size()) check("t4_data", 32'(push_log[k]), 32'(8'h81 + k));
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Test 5: reset while locked with two beats buffered.
        do_reset();
        full = 1'b1;
        for (int k = 0; k < 4; k++) add_beat(2, k == 3, 8'(8'hA0 + k));
        apply();
        ticks(3); #1;
        check("t5_busy_pre", 32'(busy), 32'd1);
        check("t5_ready_pre", 32'(req_ready), 32'd0);
        rst  = 1'b1;
        full = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        apply();
        tick(); #1;
        check("t5_push", 32'(push), 32'd0);
        check("t5_ready", 32'(req_ready), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Test 6: wr_rst_busy blocks arbitration until it falls.
        do_reset();
        wr_rst_busy = 1'b1;
        add_beat(0, 1'b1, 8'h91);
        apply();
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            check("t6_ready_hold", 32'(req_ready), 32'd0);
            check("t6_push_hold", 32'(push), 32'd0);
        end
        wr_rst_busy = 1'b0;
        tick(); #1;
        check("t6_grant", 32'(req_ready), 32'h1);
        ticks(4);
        check("t6_drained", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
